ejector_rr: RTL and testbench

EJECTOR_RR -- requirements
Module: ejector_rr

---
 rtl/minbd_pkg.sv | 29 ++
 rtl/eject_fifo.sv | 47 ++++
 rtl/ejector_rr.sv | 133 +++++++++++++
 tb/tb_ejector_rr.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minbd_pkg.sv
// Shared flit-field layout, direction encodings and helpers for the
// minimally-buffered deflection router ejection stage.
package minbd_pkg;

  localparam int DIR_W    = 3;
  localparam int ADDR_LSB = 0;

  localparam logic [DIR_W-1:0] DIR_EAST    = 3'b000;
  localparam logic [DIR_W-1:0] DIR_WEST    = 3'b001;
  localparam logic [DIR_W-1:0] DIR_NORTH   = 3'b010;
  localparam logic [DIR_W-1:0] DIR_SOUTH   = 3'b011;
  localparam logic [DIR_W-1:0] DIR_DEFLECT = 3'b100;

  // Flit layout is {gs, dir, addr}; offsets depend on the address width.
  function automatic int dir_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int gs_lsb(input int addr_w);
    return addr_w + DIR_W;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input int b);
    int s;
    s = int'(a) + b;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// Ejection buffer: up to NW writes per cycle (in order), one read per cycle.
// Head data reads as zero while empty.
module eject_fifo #(
  parameter  int W     = 11,
  parameter  int DEPTH = 4,
  parameter  int NW    = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int GW    = $clog2(NW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GW-1:0]        wr_cnt,
  input  logic [NW-1:0][W-1:0] wr_data,
  input  logic                 rd,
  output logic [W-1:0]         rd_data,
  output logic                 valid,
  output logic [CW-1:0]        count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Storage is not reset; emptiness is tracked purely by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NW; i++) begin
      if (i < int'(wr_cnt)) mem[wptr + AW'(i)] <= wr_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_cnt);
      rptr  <= rptr + AW'(rd);
      count <= count + CW'(wr_cnt) - CW'(rd);
    end
  end

  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rptr] : '0;

endmodule

// File: rtl/ejector_rr.sv
// Ejection stage: routes each incoming flit, ejects local-destined flits in
// round-robin order into a local buffer, and deflects the ones that do not fit.
module ejector_rr
  import minbd_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int ADDR_W     = 6,
  parameter  int GS_W       = 2,
  parameter  int MY_ROW     = 4,
  parameter  int MY_COL     = 4,
  parameter  int EJECT_MAX  = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int FLIT_W     = GS_W + DIR_W + ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [FLIT_W-1:0]           local_flit,
  output logic                        local_valid,
  input  logic                        local_ready,
  output logic [15:0]                 eject_cnt,
  output logic [15:0]                 deflect_cnt
);

  localparam int HALF   = ADDR_W / 2;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int GW     = $clog2(EJECT_MAX + 1);
  localparam int DW     = $clog2(NUM_PORTS + 1);
  localparam int GS_LSB = gs_lsb(ADDR_W);
  localparam logic [HALF-1:0] ROW_ID = HALF'(MY_ROW);
  localparam logic [HALF-1:0] COL_ID = HALF'(MY_COL);

  wire  [NUM_PORTS-1:0][FLIT_W-1:0] port_flit;
  wire  [NUM_PORTS-1:0]             is_local;
  wire  [NUM_PORTS-1:0][DIR_W-1:0]  route_dir;
  wire  [NUM_PORTS-1:0][FLIT_W-1:0] next_flit;
  wire  [NUM_PORTS-1:0]             next_valid;

  logic [NUM_PORTS-1:0]             grant;
  logic [EJECT_MAX-1:0][FLIT_W-1:0] wr_data;
  logic [GW-1:0]                    wr_cnt;
  logic [DW-1:0]                    defl_n;
  logic [PW-1:0]                    rr_ptr;
  logic [PW-1:0]                    rr_next;
  logic [CW-1:0]                    fifo_count;

  assign port_flit = in_flit;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    wire [FLIT_W-1:0] f   = port_flit[p];
    wire [HALF-1:0]   row = f[ADDR_W-1:HALF];
    wire [HALF-1:0]   col = f[HALF-1:0];

    // X routing first, then Y; an exact match is the local node.
    assign route_dir[p] = (col > COL_ID) ? DIR_EAST  :
                          (col < COL_ID) ? DIR_WEST  :
                          (row > ROW_ID) ? DIR_NORTH :
                          (row < ROW_ID) ? DIR_SOUTH : DIR_DEFLECT;
    assign is_local[p]   = in_valid[p] && (col == COL_ID) && (row == ROW_ID);
    assign next_valid[p] = in_valid[p] && !grant[p];
    assign next_flit[p]  = next_valid[p] ?
                           {f[FLIT_W-1:GS_LSB], route_dir[p], f[ADDR_W-1:0]} : '0;
  end

  // Budget uses the count at cycle start; a same-cycle read frees nothing.
  always_comb begin
    int budget;
    int n;
    int idx;
    grant   = '0;
    wr_data = '0;
    wr_cnt  = '0;
    defl_n  = '0;
    rr_next = rr_ptr;
    budget  = FIFO_DEPTH - int'(fifo_count);
    if (budget > EJECT_MAX) budget = EJECT_MAX;
    n = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q == idx && is_local[q] && n < budget) begin
          grant[q] = 1'b1;
          for (int j = 0; j < EJECT_MAX; j++) begin
            if (j == n) wr_data[j] = port_flit[q];
          end
          rr_next = PW'((q + 1) % NUM_PORTS);
          n = n + 1;
        end
      end
    end
    wr_cnt = GW'(n);
    for (int q = 0; q < NUM_PORTS; q++) begin
      if (is_local[q] && !grant[q]) defl_n = defl_n + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit    <= '0;
      out_valid   <= '0;
      rr_ptr      <= '0;
      eject_cnt   <= '0;
      deflect_cnt <= '0;
    end else begin
      out_flit    <= next_flit;
      out_valid   <= next_valid;
      rr_ptr      <= rr_next;
      eject_cnt   <= sat_add16(eject_cnt, int'(wr_cnt));
      deflect_cnt <= sat_add16(deflect_cnt, int'(defl_n));
    end
  end

  eject_fifo #(
    .W     (FLIT_W),
    .DEPTH (FIFO_DEPTH),
    .NW    (EJECT_MAX)
  ) u_eject_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_cnt  (wr_cnt),
    .wr_data (wr_data),
    .rd      (local_valid && local_ready),
    .rd_data (local_flit),
    .valid   (local_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_ejector_rr.sv
// Bench for ejector_rr: two instances (EJECT_MAX 1 and 2) share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_ejector_rr;

  localparam int NP    = 4;
  localparam int FW    = 11;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP*FW-1:0]  in_flit;
  logic [NP-1:0]     in_valid;
  logic              local_ready;
  logic [NP*FW-1:0]  o_flit  [2];
  logic [NP-1:0]     o_valid [2];
  logic [FW-1:0]     l_flit  [2];
  logic              l_valid [2];
  logic [15:0]       e_cnt   [2];
  logic [15:0]       d_cnt   [2];

  ejector_rr #(.EJECT_MAX(1)) dut_a (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .out_flit(o_flit[0]), .out_valid(o_valid[0]), .local_flit(l_flit[0]),
    .local_valid(l_valid[0]), .local_ready(local_ready),
    .eject_cnt(e_cnt[0]), .deflect_cnt(d_cnt[0])
  );

  ejector_rr #(.EJECT_MAX(2)) dut_b (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .out_flit(o_flit[1]), .out_valid(o_valid[1]), .local_flit(l_flit[1]),
    .local_valid(l_valid[1]), .local_ready(local_ready),
    .eject_cnt(e_cnt[1]), .deflect_cnt(d_cnt[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one set per instance.
  logic [FW-1:0]    exp_q0[$];
  logic [FW-1:0]    exp_q1[$];
  int               emax  [2];
  int               m_rr  [2];
  int               m_ej  [2];
  int               m_df  [2];
  logic [NP*FW-1:0] m_oflit [2];
  logic [NP-1:0]    m_ovalid[2];

  typedef struct {
    logic [NP*FW-1:0] flits;
    logic [NP-1:0]    valid;
    logic [NP*FW-1:0] exp_flits;
    logic [NP-1:0]    exp_valid;
  } vec_t;

  vec_t vt[8];

  function automatic logic [NP*FW-1:0] pack4(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                            input logic [FW-1:0] c, input logic [FW-1:0] d);
    return {d, c, b, a};
  endfunction

  // 0 east, 1 west, 2 north, 3 south, 4 local (node at row 4, col 4).
  function automatic int route(input logic [FW-1:0] f);
    int addr, row, col;
    addr = int'(f) % 64;
    row  = addr / 8;
    col  = addr % 8;
    if (col > 4) return 0;
    if (col < 4) return 1;
    if (row > 4) return 2;
    if (row < 4) return 3;
    return 4;
  endfunction

  function automatic logic [FW-1:0] with_dir(input logic [FW-1:0] f, input int d);
    int v;
    v = (int'(f) & ~(7 << 6)) | (d << 6);
    return FW'(v);
  endfunction

  function automatic int q_size(input int u);
    return (u == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [FW-1:0] q_head(input int u);
    if (q_size(u) == 0) return '0;
    return (u == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void q_push(input int u, input logic [FW-1:0] f);
    if (u == 0) exp_q0.push_back(f);
    else exp_q1.push_back(f);
  endfunction

  function automatic void q_pop(input int u);
    if (u == 0) void'(exp_q0.pop_front());
    else void'(exp_q1.pop_front());
  endfunction

  task automatic chk(input string name, input int u, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, u, act, exp);
    end
  endtask

  task automatic model_step(input int u);
    int size, budget, n, p, d, nr;
    logic [FW-1:0] f;
    logic [NP-1:0] g;
    if (rst) begin
      if (u == 0) exp_q0.delete();
      else exp_q1.delete();
      m_rr[u] = 0; m_ej[u] = 0; m_df[u] = 0;
      m_oflit[u] = '0; m_ovalid[u] = '0;
      return;
    end
    size   = q_size(u);
    budget = DEPTH - size;
    if (budget > emax[u]) budget = emax[u];
    if (size > 0 && local_ready) q_pop(u);
    g  = '0;
    n  = 0;
    nr = m_rr[u];
    for (int k = 0; k < NP; k++) begin
      p = (m_rr[u] + k) % NP;
      f = in_flit[p*FW +: FW];
      if (in_valid[p] && route(f) == 4 && n < budget) begin
        g[p] = 1'b1;
        q_push(u, f);
        n++;
        nr = (p + 1) % NP;
      end
    end
    m_rr[u] = nr;
    for (int q = 0; q < NP; q++) begin
      f = in_flit[q*FW +: FW];
      if (!in_valid[q] || g[q]) begin
        m_oflit[u][q*FW +: FW] = '0;
        m_ovalid[u][q] = 1'b0;
      end else begin
        d = route(f);
        if (d == 4) m_df[u]++;
        m_oflit[u][q*FW +: FW] = with_dir(f, d);
        m_ovalid[u][q] = 1'b1;
      end
    end
    m_ej[u] += n;
    if (m_ej[u] > 65535) m_ej[u] = 65535;
    if (m_df[u] > 65535) m_df[u] = 65535;
  endtask

  // One clock: check buffer head, advance model, then check registered outputs.
  task automatic cycle();
    for (int u = 0; u < 2; u++) begin
      chk("local_valid", u, 64'(l_valid[u]), 64'(q_size(u) > 0));
      chk("local_flit", u, 64'(l_flit[u]), 64'(q_head(u)));
    end
    for (int u = 0; u < 2; u++) model_step(u);
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("out_flit", u, 64'(o_flit[u]), 64'(m_oflit[u]));
      chk("out_valid", u, 64'(o_valid[u]), 64'(m_ovalid[u]));
      chk("eject_cnt", u, 64'(e_cnt[u]), 64'(m_ej[u]));
      chk("deflect_cnt", u, 64'(d_cnt[u]), 64'(m_df[u]));
    end
  endtask

  task automatic clear_in();
    in_flit  = '0;
    in_valid = '0;
  endtask

  task automatic set_port(input int p, input logic [FW-1:0] f);
    in_flit[p*FW +: FW] = f;
    in_valid[p] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    local_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int row, col;
    logic [FW-1:0] f;

    emax[0] = 1; emax[1] = 2;
    for (int u = 0; u < 2; u++) begin
      m_rr[u] = 0; m_ej[u] = 0; m_df[u] = 0;
      m_oflit[u] = '0; m_ovalid[u] = '0;
    end

    // Clock/reset.
    rst = 1'b1;
    local_ready = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset_out_flit", u, 64'(o_flit[u]), 64'd0);
      chk("reset_out_valid", u, 64'(o_valid[u]), 64'd0);
      chk("reset_local_valid", u, 64'(l_valid[u]), 64'd0);
      chk("reset_local_flit", u, 64'(l_flit[u]), 64'd0);
      chk("reset_eject_cnt", u, 64'(e_cnt[u]), 64'd0);
      chk("reset_deflect_cnt", u, 64'(d_cnt[u]), 64'd0);
    end
    rst = 1'b0;

    // Single-cycle routing vectors, each from a fresh reset.
    vt[0] = '{pack4(0, 0, 11'h026, 0), 4'b0100, pack4(0, 0, 11'h026, 0), 4'b0100};
    vt[1] = '{pack4(11'h034, 0, 0, 0), 4'b0001, pack4(11'h0B4, 0, 0, 0), 4'b0001};
    vt[2] = '{pack4(0, 11'h022, 0, 0), 4'b0010, pack4(0, 11'h062, 0, 0), 4'b0010};
    vt[3] = '{pack4(0, 0, 0, 11'h7D4), 4'b1000, pack4(0, 0, 0, 11'h6D4), 4'b1000};
    vt[4] = '{pack4(11'h7FF, 0, 0, 0), 4'b0000, pack4(0, 0, 0, 0), 4'b0000};
    vt[5] = '{pack4(0, 0, 11'h224, 0), 4'b0100, pack4(0, 0, 0, 0), 4'b0000};
    vt[6] = '{pack4(11'h026, 11'h034, 11'h022, 11'h014), 4'b1111,
              pack4(11'h026, 11'h0B4, 11'h062, 11'h0D4), 4'b1111};
    vt[7] = '{pack4(11'h438, 0, 0, 0), 4'b0001, pack4(11'h478, 0, 0, 0), 4'b0001};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      in_flit  = vt[i].flits;
      in_valid = vt[i].valid;
      cycle();
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("vec%0d_flit", i), u, 64'(o_flit[u]), 64'(vt[i].exp_flits));
        chk($sformatf("vec%0d_valid", i), u, 64'(o_valid[u]), 64'(vt[i].exp_valid));
      end
    end

    // All four ports local for two cycles with the sink stalled.
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 11'h224);
    cycle();
    chk("burst_c1_valid", 0, 64'(o_valid[0]), 64'(4'b1110));
    chk("burst_c1_flit", 0, 64'(o_flit[0]), 64'(pack4(0, 11'h324, 11'h324, 11'h324)));
    cycle();
    chk("burst_c2_valid", 0, 64'(o_valid[0]), 64'(4'b1101));
    chk("burst_eject_cnt", 0, 64'(e_cnt[0]), 64'd2);
    chk("burst_deflect_cnt", 0, 64'(d_cnt[0]), 64'd6);

    // Reset with a partly filled buffer and valid outputs in flight.
    clear_in();
    set_port(2, 11'h026);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_local_valid", 0, 64'(l_valid[0]), 64'd0);
    chk("rst_out_valid", 0, 64'(o_valid[0]), 64'd0);
    chk("rst_eject_cnt", 0, 64'(e_cnt[0]), 64'd0);
    chk("rst_deflect_cnt", 0, 64'(d_cnt[0]), 64'd0);

    // Full buffer: a same-cycle read must not open a slot.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clear_in();
      set_port(0, FW'(11'h024 | (i << 9)));
      cycle();
    end
    clear_in();
    set_port(3, 11'h024);
    local_ready = 1'b1;
    cycle();
    chk("full_deflect_valid", 0, 64'(o_valid[0][3]), 64'd1);
    chk("full_deflect_flit", 0, 64'(o_flit[0][3*FW +: FW]), 64'(11'h124));
    local_ready = 1'b0;
    chk("full_head_after_read", 0, 64'(l_flit[0]), 64'(11'h224));
    cycle();
    chk("full_then_grant", 0, 64'(o_valid[0][3]), 64'd0);

    // Two ejections per cycle starting from rr_ptr 2.
    do_reset();
    set_port(1, 11'h024);
    local_ready = 1'b1;
    cycle();
    local_ready = 1'b0;
    clear_in();
    set_port(1, 11'h024);
    set_port(3, 11'h2E4);
    cycle();
    chk("dual_both_ejected", 1, 64'(o_valid[1]), 64'd0);
    clear_in();
    set_port(1, 11'h024);
    set_port(2, 11'h024);
    cycle();
    chk("dual_rr_kept_valid", 1, 64'(o_valid[1]), 64'(4'b0010));
    chk("dual_rr_kept_flit", 1, 64'(o_flit[1][FW +: FW]), 64'(11'h124));
    clear_in();
    local_ready = 1'b1;
    chk("dual_order_0", 1, 64'(l_flit[1]), 64'(11'h024));
    cycle();
    chk("dual_order_1", 1, 64'(l_flit[1]), 64'(11'h2E4));
    cycle();
    chk("dual_order_2", 1, 64'(l_flit[1]), 64'(11'h024));

    // Randomized traffic biased toward the local node.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      local_ready = ($urandom_range(0, 2) != 0);
      clear_in();
      for (int p = 0; p < NP; p++) begin
        row = $urandom_range(0, 1) ? 4 : int'($urandom_range(0, 7));
        col = $urandom_range(0, 1) ? 4 : int'($urandom_range(0, 7));
        f = FW'((int'($urandom_range(0, 3)) << 9) | (int'($urandom_range(0, 7)) << 6) |
                (row << 3) | col);
        in_flit[p*FW +: FW] = f;
        in_valid[p] = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    rst = 1'b0;

    // Counter saturation under sustained deflection.
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 11'h224);
    for (int i = 0; i < 16400; i++) cycle();
    chk("deflect_saturate", 0, 64'(d_cnt[0]), 64'h0000_0000_0000_FFFF);
    chk("deflect_saturate", 1, 64'(d_cnt[1]), 64'h0000_0000_0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
